// File: rtl/fsm.sv
// -----------------------------------------------------------------------------
// fsm -- three-state Moore sequence detector.
//
// Walks IDLE -> STATE_1 -> FINAL while `a` stays high and falls back to IDLE
// whenever `a` is low. FINAL holds for as long as `a` stays high. The unused
// code 2'b11 always recovers to IDLE on the next edge.
//
// Ports:
//   clk    in   single clock; all state updates occur on its rising edge
//   reset  in   asynchronous, active-high; forces IDLE and clears outputs
//   a      in   control input sampled on each rising edge of clk
//   out1   out  high while the machine is in STATE_1
//   out2   out  high while the machine is in FINAL
// -----------------------------------------------------------------------------
module fsm (
    input  logic clk,
    input  logic reset,
    input  logic a,
    output logic out1,
    output logic out2
);

    // Fixed 2-bit binary encoding; 2'b11 is illegal and is caught by default.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        STATE_1 = 2'b01,
        FINAL   = 2'b10
    } state_t;

    // Declaration initialisers give a defined IDLE state and low outputs at
    // time zero, so outputs are never X even if reset is never pulsed.
    state_t state      = IDLE;
    state_t next_state;
    logic   out1_q     = 1'b0;
    logic   out2_q     = 1'b0;
    logic   next_out1;
    logic   next_out2;

    // State register. The outputs are registered alongside the state from the
    // decode of next_state, so they change in the same cycle as the state
    // transition but cannot glitch while both state bits switch (01 -> 10).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            out1_q <= 1'b0;
            out2_q <= 1'b0;
        end else begin
            state  <= next_state;
            out1_q <= next_out1;
            out2_q <= next_out2;
        end
    end

    // Next-state logic and Moore decode of the state being entered.
    always_comb begin
        next_state = IDLE;
        next_out1  = 1'b0;
        next_out2  = 1'b0;

        case (state)
            IDLE:    next_state = a ? STATE_1 : IDLE;
            STATE_1: next_state = a ? FINAL   : IDLE;
            FINAL:   next_state = a ? FINAL   : IDLE;
            default: next_state = IDLE;
        endcase

        // out1 and out2 decode distinct states, so they are mutually exclusive.
        next_out1 = (next_state == STATE_1);
        next_out2 = (next_state == FINAL);
    end

    assign out1 = out1_q;
    assign out2 = out2_q;

endmodule

// File: tb/tb_fsm.sv
// -----------------------------------------------------------------------------
// tb_fsm -- directed self-checking bench for fsm.
//
// Inputs are driven 1 ns after each rising edge and outputs are checked 1 ns
// after the edge that should produce them. A background monitor on the
// falling edge confirms out1/out2 are known and never both high.
// -----------------------------------------------------------------------------
module tb_fsm;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic a     = 1'b0;
    logic out1;
    logic out2;

    int n_checks = 0;
    int n_pass   = 0;
    logic monitor_on = 1'b1;

    fsm dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .out1  (out1),
        .out2  (out2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b, expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply `a` for one edge, then check {out1,out2} just after that edge.
    task automatic step(input string tag, input logic av, input logic [1:0] exp);
        a = av;
        @(posedge clk);
        #1;
        check(tag, {out1, out2}, exp);
    endtask

    // Per-cycle sanity: outputs known and mutually exclusive.
    always @(negedge clk) begin
        if (monitor_on) begin
            check("known", {1'b0, $isunknown({out1, out2})}, 2'b00);
            check("excl",  {1'b0, out1 & out2}, 2'b00);
        end
    end

    initial begin
        // Reset asserted from time zero: outputs low before any clock edge.
        #1;
        check("rst_async_init", {out1, out2}, 2'b00);

        // Reset dominates a=1 across edges.
        step("rst_prio_1", 1'b1, 2'b00);
        step("rst_prio_2", 1'b1, 2'b00);

        // Release reset away from an edge.
        a = 1'b0;
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle", {out1, out2}, 2'b00);

        // Stay in IDLE with a=0.
        step("idle_hold_1", 1'b0, 2'b00);
        step("idle_hold_2", 1'b0, 2'b00);

        // IDLE -> STATE_1 -> FINAL -> FINAL.
        step("to_state1",   1'b1, 2'b10);
        step("to_final",    1'b1, 2'b01);
        step("final_hold",  1'b1, 2'b01);

        // FINAL -> IDLE.
        step("final_exit",  1'b0, 2'b00);

        // STATE_1 aborts to IDLE.
        step("abort_s1",    1'b1, 2'b10);
        step("abort_idle",  1'b0, 2'b00);

        // Toggling a between edges has no effect on outputs.
        step("glitch_s1",   1'b1, 2'b10);
        #2; a = 1'b0;
        #1; check("no_mealy_1", {out1, out2}, 2'b10);
        a = 1'b1;
        #1; check("no_mealy_2", {out1, out2}, 2'b10);
        step("glitch_final", 1'b1, 2'b01);

        // Asynchronous reset while in FINAL, between edges.
        #3;
        reset = 1'b1;
        #1;
        check("rst_mid_final", {out1, out2}, 2'b00);
        #1;
        reset = 1'b0;
        // Next edge is the first edge after release: normal rules from IDLE.
        @(posedge clk);
        #1;
        check("post_rst_s1", {out1, out2}, 2'b10);
        step("post_rst_final", 1'b1, 2'b01);

        // Async reset while in STATE_1.
        step("s1_again_idle", 1'b0, 2'b00);
        step("s1_again",      1'b1, 2'b10);
        #3;
        reset = 1'b1;
        #1;
        check("rst_mid_s1", {out1, out2}, 2'b00);
        #1;
        reset = 1'b0;
        a = 1'b0;
        @(posedge clk);
        #1;
        check("rst_s1_idle", {out1, out2}, 2'b00);

        monitor_on = 1'b0;
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
